brdg_wdata_sender: RTL

Write-data sender for the TLX command path. It snoops the command stream leaving the context-surveillance stage and, for every DMA write or partial write, pops the matching number of 64-byte beats from the upstream write-data buffer. It drives them onto the AFU→TLX command-data bus under TLX command-data credit control, preserving command order.

---
 rtl/brdg_wdata_sender_pkg.sv | 30 +++
 rtl/brdg_wdata_sender_if.sv | 35 +++
 rtl/brdg_req_fifo.sv | 54 +++++
 rtl/brdg_wdata_sender.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/brdg_wdata_sender_pkg.sv
// Shared definitions for the TLX write-data sender: opcodes, data-length
// encodings, FSM states and the dl-to-beat-count mapping.
package brdg_wdata_sender_pkg;

  localparam logic [7:0] DMA_W    = 8'h20;
  localparam logic [7:0] DMA_PR_W = 8'h30;

  localparam logic [1:0] DL_ZERO = 2'b00;
  localparam logic [1:0] DL_64B  = 2'b01;
  localparam logic [1:0] DL_128B = 2'b10;
  localparam logic [1:0] DL_256B = 2'b11;

  localparam int BEAT_CNT_W = 3;
  typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // An illegal dl of 00 is treated as a single beat so the data stream stays aligned.
  function automatic beat_cnt_t dl_to_beats(input logic [1:0] dl);
    case (dl)
      DL_128B: return beat_cnt_t'(2);
      DL_256B: return beat_cnt_t'(4);
      default: return beat_cnt_t'(1);
    endcase
  endfunction

endpackage

// File: rtl/brdg_wdata_sender_if.sv
// Command snoop, upstream write-data and TLX command-data signals of the sender.
// master = the surrounding bridge / TLX side, slave = the sender itself.
interface brdg_wdata_sender_if #(
  parameter int DATA_W = 512,
  parameter int CRED_W = 6
);
  logic              cmd_valid;
  logic [7:0]        cmd_opcode;
  logic [1:0]        cmd_dl;
  logic              wd_valid;
  logic [DATA_W-1:0] wd_data;
  logic              wd_bdi;
  logic              wd_ready;
  logic [CRED_W-1:0] tlx_afu_cmd_data_initial_credit;
  logic              tlx_afu_cmd_data_credit;
  logic              afu_tlx_cdata_valid;
  logic [DATA_W-1:0] afu_tlx_cdata_bus;
  logic              afu_tlx_cdata_bdi;

  modport master (
    output cmd_valid, cmd_opcode, cmd_dl,
    output wd_valid, wd_data, wd_bdi,
    input  wd_ready,
    output tlx_afu_cmd_data_initial_credit, tlx_afu_cmd_data_credit,
    input  afu_tlx_cdata_valid, afu_tlx_cdata_bus, afu_tlx_cdata_bdi
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_dl,
    input  wd_valid, wd_data, wd_bdi,
    output wd_ready,
    input  tlx_afu_cmd_data_initial_credit, tlx_afu_cmd_data_credit,
    output afu_tlx_cdata_valid, afu_tlx_cdata_bus, afu_tlx_cdata_bdi
  );
endinterface

// File: rtl/brdg_req_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy counter.
// DEPTH must be a power of two (>= 2); a pop while full frees the slot for a same-cycle push.
module brdg_req_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and count alone define validity, so the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/brdg_wdata_sender.sv
// TLX write-data sender: snoops DMA writes, queues their beat counts and streams
// the matching upstream data beats onto the command-data bus under credit control.
module brdg_wdata_sender
  import brdg_wdata_sender_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int REQ_DEPTH = 4,
  parameter int CRED_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  brdg_wdata_sender_if.slave  bus_if,
  output logic                req_overflow,
  output logic                credit_overflow,
  output logic                dl_error
);

  state_e                         state_q;
  beat_cnt_t                      beats_left;
  logic [CRED_W-1:0]              credit_q;
  logic                           init_done;

  logic                           req_push;
  beat_cnt_t                      req_beats;
  logic                           req_pop;
  beat_cnt_t                      req_rdata;
  logic                           req_full;
  logic                           req_empty;
  logic [$clog2(REQ_DEPTH+1)-1:0] req_count;
  logic                           is_dma_w;
  logic                           fire;
  logic                           last_beat;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_dma_w  = 1'b0;
    req_push  = 1'b0;
    req_beats = beat_cnt_t'(1);
    if (bus_if.cmd_valid) begin
      if (bus_if.cmd_opcode == DMA_W) begin
        is_dma_w  = 1'b1;
        req_push  = 1'b1;
        req_beats = dl_to_beats(bus_if.cmd_dl);
      end else if (bus_if.cmd_opcode == DMA_PR_W) begin
        req_push  = 1'b1;
      end
    end
  end

  brdg_req_fifo #(
    .WIDTH (BEAT_CNT_W),
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_push),
    .wdata (req_beats),
    .pop   (req_pop),
    .rdata (req_rdata),
    .full  (req_full),
    .empty (req_empty),
    .count (req_count)
  );

  assign fire      = (state_q == ST_SEND) && bus_if.wd_valid && (credit_q != '0) && init_done;
  assign last_beat = fire && (beats_left == beat_cnt_t'(1));
  // Popping on the last beat lets the next burst follow without an idle cycle.
  assign req_pop   = !req_empty && ((state_q == ST_IDLE) || last_beat);

  assign bus_if.wd_ready = fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beats_left <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_pop) begin
            beats_left <= req_rdata;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (req_pop) begin
            beats_left <= req_rdata;
          end else if (last_beat) begin
            beats_left <= '0;
            state_q    <= ST_IDLE;
          end else if (fire) begin
            beats_left <= beats_left - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The initial credit level is only valid once reset is released, so it loads one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q        <= '0;
      init_done       <= 1'b0;
      credit_overflow <= 1'b0;
    end else if (!init_done) begin
      credit_q  <= bus_if.tlx_afu_cmd_data_initial_credit;
      init_done <= 1'b1;
    end else begin
      case ({fire, bus_if.tlx_afu_cmd_data_credit})
        2'b10: credit_q <= credit_q - 1'b1;
        2'b01: begin
          if (&credit_q) credit_overflow <= 1'b1;
          else           credit_q        <= credit_q + 1'b1;
        end
        default: credit_q <= credit_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_overflow <= 1'b0;
      dl_error     <= 1'b0;
    end else begin
      if (req_push && req_full && !req_pop)                 req_overflow <= 1'b1;
      if (is_dma_w && (bus_if.cmd_dl == DL_ZERO))           dl_error     <= 1'b1;
    end
  end

  // Bus and bdi only load on a fired beat, so they hold their last value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_if.afu_tlx_cdata_valid <= 1'b0;
      bus_if.afu_tlx_cdata_bus   <= '0;
      bus_if.afu_tlx_cdata_bdi   <= 1'b0;
    end else begin
      bus_if.afu_tlx_cdata_valid <= fire;
      if (fire) begin
        bus_if.afu_tlx_cdata_bus <= bus_if.wd_data;
        bus_if.afu_tlx_cdata_bdi <= bus_if.wd_bdi;
      end
    end
  end

endmodule
